// File: rtl/unary_emitter.sv
// Unary (thermometer or bit-reversed spread) stream emitter: turns an accepted
// binary count into a window of 2^VAL_WIDTH-1 beats carrying exactly that many ones.
module unary_emitter #(
    parameter int VAL_WIDTH = 8,
    parameter bit SPREAD    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VAL_WIDTH-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [VAL_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [VAL_WIDTH-1:0] LAST_CNT = ALL_ONES - VAL_WIDTH'(1);

    logic [0:0]           state_q, state_d;
    logic [VAL_WIDTH-1:0] cnt_q, cnt_d;
    logic [VAL_WIDTH-1:0] val_q, val_d;
    logic [VAL_WIDTH-1:0] cmp_idx;
    logic                 streaming, beat, accept;

    // Bit-reversing the counter visits every index except all-ones exactly
    // once, so both orders emit exactly val ones per window.
    always_comb begin
        cmp_idx = cnt_q;
        if (SPREAD) begin
            for (int i = 0; i < VAL_WIDTH; i++) begin
                cmp_idx[i] = cnt_q[VAL_WIDTH-1-i];
            end
        end
    end

    assign streaming = (state_q == STREAM);
    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_last  = streaming & (cnt_q == LAST_CNT);
    assign out_bit   = streaming & (cmp_idx < val_q);

    assign beat     = out_valid & out_ready;
    assign in_ready = ~streaming | (beat & out_last);
    assign accept   = in_valid & in_ready & ~clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            val_d   = '0;
        end else if (accept) begin
            // Also covers the back-to-back case on a last beat: no bubble.
            state_d = STREAM;
            cnt_d   = '0;
            val_d   = in_value;
        end else if (beat) begin
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + VAL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_unary_emitter.sv
// Randomized bench for unary_emitter: four instances (W8 thermometer, W8 spread,
// W4 spread loopback, W1) checked every cycle against a beat-index reference model.
module tb_unary_emitter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus groups: 0 drives both W8 instances, 1 the W4 one, 2 the W1 one.
    logic       iv   [3];
    logic       clr  [3];
    logic       ordy [3];
    logic [7:0] val  [3];

    logic ov [4];
    logic rdy[4];
    logic ob [4];
    logic ol [4];
    logic bz [4];

    int nchk = 0;
    int nfail = 0;

    int m_act [4];
    int m_k   [4];
    int m_v   [4];
    int m_acc [4];
    int wins  [4];

    unary_emitter #(.VAL_WIDTH(8), .SPREAD(1'b0)) u_therm (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_value(val[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]),
        .out_last(ol[0]), .busy(bz[0]));

    unary_emitter #(.VAL_WIDTH(8), .SPREAD(1'b1)) u_spread (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(rdy[1]),
        .in_value(val[0]), .out_valid(ov[1]), .out_ready(ordy[0]), .out_bit(ob[1]),
        .out_last(ol[1]), .busy(bz[1]));

    unary_emitter #(.VAL_WIDTH(4), .SPREAD(1'b1)) u_loop (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(rdy[2]),
        .in_value(val[1][3:0]), .out_valid(ov[2]), .out_ready(ordy[1]), .out_bit(ob[2]),
        .out_last(ol[2]), .busy(bz[2]));

    unary_emitter #(.VAL_WIDTH(1), .SPREAD(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(rdy[3]),
        .in_value(val[2][0:0]), .out_valid(ov[3]), .out_ready(ordy[2]), .out_bit(ob[3]),
        .out_last(ol[3]), .busy(bz[3]));

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int wid(input int id);
        case (id)
            0, 1:    return 8;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int grp(input int id);
        return (id < 2) ? 0 : id - 1;
    endfunction

    // Beat k of a window carries a one when its (optionally reversed) index is below v.
    function automatic bit ref_bit(input int k, input int v, input int w, input bit spr);
        int r;
        r = k;
        if (spr) begin
            r = 0;
            for (int i = 0; i < w; i++) r = r * 2 + ((k >> i) & 1);
        end
        return r < v;
    endfunction

    task automatic model_step(input int id);
        int g, w, win, ir_e, last_e, bit_e, beat, acc;
        g      = grp(id);
        w      = wid(id);
        win    = (1 << w) - 1;
        last_e = (m_act[id] != 0) && (m_k[id] == win - 1);
        bit_e  = (m_act[id] != 0) && ref_bit(m_k[id], m_v[id], w, (id == 1) || (id == 2));
        ir_e   = (m_act[id] == 0) || (ordy[g] && last_e);
        chk($sformatf("outs%0d", id),
            {27'd0, ov[id], bz[id], ob[id], ol[id], rdy[id]},
            {27'd0, m_act[id] != 0, m_act[id] != 0, bit_e[0], last_e[0], ir_e[0]});
        beat = (m_act[id] != 0) && ordy[g];
        acc  = iv[g] && (ir_e != 0) && !clr[g];
        if (clr[g]) begin
            m_act[id] = 0;
        end else begin
            if (beat != 0) begin
                m_acc[id] += int'(ob[id]);
                if (last_e != 0) begin
                    chk($sformatf("ones%0d", id), m_acc[id], m_v[id]);
                    m_act[id] = 0;
                    wins[id]++;
                end else begin
                    m_k[id]++;
                end
            end
            if (acc != 0) begin
                m_act[id] = 1;
                m_k[id]   = 0;
                m_v[id]   = int'(val[g]) & win;
                m_acc[id] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int id = 0; id < 4; id++) m_act[id] = 0;
            end else begin
                for (int id = 0; id < 4; id++) model_step(id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_ready(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return $urandom_range(1, 0) == 1;
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    task automatic send(input int g, input int v, input int mode);
        bit took;
        int fid;
        fid  = (g == 0) ? 0 : g + 1;
        took = 1'b0;
        iv[g]  = 1'b1;
        val[g] = 8'(v);
        for (int n = 0; n < 3000 && !took; n++) begin
            ordy[g] = rnd_ready(mode);
            #1;
            took = rdy[fid] && !clr[g];
            tick();
        end
        if (!took) chk("send_timeout", 0, 1);
        iv[g] = 1'b0;
    endtask

    task automatic drain(input int g, input int mode);
        int fid;
        bit done;
        fid  = (g == 0) ? 0 : g + 1;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (!ov[fid]) done = 1'b1;
            else begin
                ordy[g] = rnd_ready(mode);
                tick();
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
        ordy[g] = 1'b1;
    endtask

    int w0;

    initial begin
        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; clr[g] = 1'b0; ordy[g] = 1'b1; val[g] = 8'd0;
        end
        for (int id = 0; id < 4; id++) begin
            m_act[id] = 0; m_k[id] = 0; m_v[id] = 0; m_acc[id] = 0; wins[id] = 0;
        end
        #3;
        for (int id = 0; id < 4; id++)
            chk($sformatf("reset%0d", id), {ov[id], bz[id], ob[id], ol[id], rdy[id]}, 5'b00001);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // All-zero and all-one windows, then thermometer 3 / spread 128.
        send(0, 0, 0);   drain(0, 0);
        send(0, 255, 0); drain(0, 0);
        send(0, 3, 0);   drain(0, 0);
        send(0, 128, 0); drain(0, 0);
        chk("wins_basic", wins[0], 4);

        // Random stalls must hold the beat.
        send(0, 100, 1); drain(0, 1);

        // Back-to-back windows: in_valid is raised again right after the first accept.
        w0 = wins[1];
        send(0, 5, 0); send(0, 250, 0); drain(0, 0);
        chk("b2b_wins", wins[1] - w0, 2);

        // Clear mid-window, then a fresh full window.
        send(0, 200, 0);
        for (int i = 0; i < 39; i++) tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("clear_ov", int'(ov[0]), 0);
        chk("clear_ir", int'(rdy[0]), 1);
        send(0, 7, 0); drain(0, 0);

        // Asynchronous reset mid-window.
        send(0, 90, 0);
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {ov[0], bz[0], ob[0], ol[0], rdy[0]}, 5'b00001);
        chk("arst_outs_s", {ov[1], bz[1], ob[1], ol[1], rdy[1]}, 5'b00001);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("arst_quiet", int'(ov[0]), 0);

        // Random values, stalls, back-to-back and occasional clears.
        for (int i = 0; i < 12; i++) begin
            send(0, $urandom_range(255, 0), $urandom_range(2, 0));
            if ($urandom_range(3, 0) == 0) begin
                for (int j = 0; j < 30; j++) tick();
                clr[0] = 1'b1; tick(); clr[0] = 1'b0;
            end else if ($urandom_range(1, 0) == 0) begin
                drain(0, $urandom_range(2, 0));
            end
        end
        drain(0, 0);

        // Loopback: ones per window accumulate back to the accepted value.
        w0 = wins[2];
        for (int i = 0; i < 1000; i++) send(1, $urandom_range(15, 0), 2);
        drain(1, 2);
        chk("loop_wins", wins[2] - w0, 1000);

        // Single-beat windows.
        w0 = wins[3];
        for (int i = 0; i < 40; i++) send(2, $urandom_range(1, 0), 1);
        drain(2, 0);
        chk("w1_wins", wins[3] - w0, 40);

        tick();
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
